// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access stage of the 5-stage MIPS core. Takes one instruction at a time
// from the execute/memory register, issues a load or store on the data bus
// using a split address/data handshake, aligns and extends load data, and
// presents a registered result to the writeback stage.
//
// Handshakes (all valid/ready pairs): a transfer happens on a cycle where both
// valid and ready are high at the rising clock edge. A valid, once raised, keeps
// its payload stable until the transfer. dreq_valid/dresp_addr_ok is the
// request pair; dresp_data_ok is a one-cycle completion pulse that is only
// honoured after the address phase has been accepted.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_*                upstream instruction (valid/ready, op, address, data)
//   dreq_*              data-bus request (valid, addr, size, strobe, data)
//   dresp_*             data-bus response (addr_ok, data_ok, load word)
//   out_*               registered result to writeback (valid/ready)
//   out_exc             address-error flags {AdES, AdEL}, only with
//                       MEM_ADDR_CHECK_EN defined
//   dbg_state           current FSM state (0 IDLE, 1 REQ, 2 WAIT)
//
// Optional feature macro: MEM_ADDR_CHECK_EN. When defined, misaligned
// half/word accesses are not sent to the bus; they complete in one cycle with
// out_result = the bad address and the matching out_exc bit set. When not
// defined, there is no out_exc port and every address goes to the bus as is.
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mem_op,
  input  logic [31:0]       in_aluout,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic [4:0]        in_writereg,
  input  logic [31:0]       in_pcplus4,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [4:0]        out_writereg,
  output logic [31:0]       out_pcplus4,
`ifdef MEM_ADDR_CHECK_EN
  output logic [1:0]        out_exc,
`endif
  output logic [1:0]        dbg_state
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t              state_q;

  // Latched operands of the memory op in flight
  logic [3:0]          op_q;
  logic [31:0]         addr_q;
  logic                store_q;
  logic [4:0]          writereg_q;
  logic [31:0]         pcplus4_q;

  // Registered bus request
  logic                dreq_valid_q;
  logic [ADDR_W-1:0]   dreq_addr_q;
  logic [1:0]          dreq_size_q;
  logic [3:0]          dreq_strobe_q;
  logic [DATA_W-1:0]   dreq_data_q;

  // Registered result
  logic                out_valid_q;
  logic [31:0]         out_result_q;
  logic [4:0]          out_writereg_q;
  logic [31:0]         out_pcplus4_q;
`ifdef MEM_ADDR_CHECK_EN
  logic [1:0]          out_exc_q;
`endif

  // Decode of the incoming instruction
  logic                is_mem_d;
  logic                is_store_d;
  logic [1:0]          size_d;
  logic [3:0]          strobe_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                bad_ld_d;
  logic                bad_st_d;

  // Load extraction from the returned word
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         result_d;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);

  always_comb begin
    is_mem_d   = 1'b0;
    is_store_d = 1'b0;
    size_d     = 2'd0;
    strobe_d   = 4'b0000;
    wdata_d    = '0;
    case (in_mem_op)
      OP_LB, OP_LBU: begin
        is_mem_d = 1'b1;
        size_d   = 2'd0;
      end
      OP_LH, OP_LHU: begin
        is_mem_d = 1'b1;
        size_d   = 2'd1;
      end
      OP_LW: begin
        is_mem_d = 1'b1;
        size_d   = 2'd2;
      end
      OP_SB: begin
        is_mem_d   = 1'b1;
        is_store_d = 1'b1;
        size_d     = 2'd0;
        strobe_d   = 4'b0001 << in_aluout[1:0];
        wdata_d    = {4{in_wdata[7:0]}};
      end
      OP_SH: begin
        is_mem_d   = 1'b1;
        is_store_d = 1'b1;
        size_d     = 2'd1;
        strobe_d   = 4'b0011 << {in_aluout[1], 1'b0};
        wdata_d    = {2{in_wdata[15:0]}};
      end
      OP_SW: begin
        is_mem_d   = 1'b1;
        is_store_d = 1'b1;
        size_d     = 2'd2;
        strobe_d   = 4'b1111;
        wdata_d    = in_wdata;
      end
      default: ;
    endcase
  end

  // Misalignment: half with addr[0]=1, word with addr[1:0]!=0. Loads raise
  // AdEL, stores AdES.
  always_comb begin
    bad_ld_d = 1'b0;
    bad_st_d = 1'b0;
`ifdef MEM_ADDR_CHECK_EN
    if (((size_d == 2'd1) && in_aluout[0]) ||
        ((size_d == 2'd2) && (in_aluout[1:0] != 2'b00))) begin
      bad_ld_d = is_mem_d && !is_store_d;
      bad_st_d = is_store_d;
    end
`endif
  end

  always_comb begin
    ld_byte = dresp_data[7:0];
    case (addr_q[1:0])
      2'd0: ld_byte = dresp_data[7:0];
      2'd1: ld_byte = dresp_data[15:8];
      2'd2: ld_byte = dresp_data[23:16];
      2'd3: ld_byte = dresp_data[31:24];
      default: ;
    endcase
    ld_half = addr_q[1] ? dresp_data[31:16] : dresp_data[15:0];

    // Stores report their address as the result
    result_d = addr_q;
    case (op_q)
      OP_LB:   result_d = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  result_d = {24'd0, ld_byte};
      OP_LH:   result_d = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  result_d = {16'd0, ld_half};
      OP_LW:   result_d = dresp_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      op_q           <= 4'd0;
      addr_q         <= 32'd0;
      store_q        <= 1'b0;
      writereg_q     <= 5'd0;
      pcplus4_q      <= 32'd0;
      dreq_valid_q   <= 1'b0;
      dreq_addr_q    <= '0;
      dreq_size_q    <= 2'd0;
      dreq_strobe_q  <= 4'd0;
      dreq_data_q    <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= 32'd0;
      out_writereg_q <= 5'd0;
      out_pcplus4_q  <= 32'd0;
`ifdef MEM_ADDR_CHECK_EN
      out_exc_q      <= 2'b00;
`endif
    end else begin
      // Drain; a result landing below in the same cycle overrides this
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            if (is_mem_d && !(bad_ld_d || bad_st_d)) begin
              op_q          <= in_mem_op;
              addr_q        <= in_aluout;
              store_q       <= is_store_d;
              writereg_q    <= in_writereg;
              pcplus4_q     <= in_pcplus4;
              dreq_valid_q  <= 1'b1;
              dreq_addr_q   <= in_aluout[ADDR_W-1:0];
              dreq_size_q   <= size_d;
              dreq_strobe_q <= strobe_d;
              dreq_data_q   <= wdata_d;
              state_q       <= ST_REQ;
            end else begin
              // NONE, unknown op, or rejected misaligned access
              out_valid_q    <= 1'b1;
              out_result_q   <= in_aluout;
              out_writereg_q <= is_mem_d ? 5'd0 : in_writereg;
              out_pcplus4_q  <= in_pcplus4;
`ifdef MEM_ADDR_CHECK_EN
              out_exc_q      <= {bad_st_d, bad_ld_d};
`endif
            end
          end
        end
        ST_REQ: begin
          if (dresp_addr_ok) begin
            dreq_valid_q <= 1'b0;
            if (dresp_data_ok) begin
              out_valid_q    <= 1'b1;
              out_result_q   <= result_d;
              out_writereg_q <= store_q ? 5'd0 : writereg_q;
              out_pcplus4_q  <= pcplus4_q;
`ifdef MEM_ADDR_CHECK_EN
              out_exc_q      <= 2'b00;
`endif
              state_q        <= ST_IDLE;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (dresp_data_ok) begin
            out_valid_q    <= 1'b1;
            out_result_q   <= result_d;
            out_writereg_q <= store_q ? 5'd0 : writereg_q;
            out_pcplus4_q  <= pcplus4_q;
`ifdef MEM_ADDR_CHECK_EN
            out_exc_q      <= 2'b00;
`endif
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dreq_valid   = dreq_valid_q;
  assign dreq_addr    = dreq_addr_q;
  assign dreq_size    = dreq_size_q;
  assign dreq_strobe  = dreq_strobe_q;
  assign dreq_data    = dreq_data_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_writereg = out_writereg_q;
  assign out_pcplus4  = out_pcplus4_q;
`ifdef MEM_ADDR_CHECK_EN
  assign out_exc      = out_exc_q;
`endif
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Directed bench for mem_access_stage. A small reference model (plain
// arithmetic on op/address/word) predicts each result and pushes it into an
// expected queue; a negedge compare process pops and checks every output
// transfer. Directed tests add hand-computed literal checks on latency, bus
// fields, hold behaviour and reset.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_mem_op;
  logic [31:0] in_aluout;
  logic [31:0] in_wdata;
  logic [4:0]  in_writereg;
  logic [31:0] in_pcplus4;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_writereg;
  logic [31:0] out_pcplus4;
`ifdef MEM_ADDR_CHECK_EN
  logic [1:0]  out_exc;
`endif
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // {result[68:37], writereg[36:32], pcplus4[31:0]}
  logic [68:0] exp_q[$];

  mem_access_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mem_op    (in_mem_op),
    .in_aluout    (in_aluout),
    .in_wdata     (in_wdata),
    .in_writereg  (in_writereg),
    .in_pcplus4   (in_pcplus4),
    .dreq_valid   (dreq_valid),
    .dreq_addr    (dreq_addr),
    .dreq_size    (dreq_size),
    .dreq_strobe  (dreq_strobe),
    .dreq_data    (dreq_data),
    .dresp_addr_ok(dresp_addr_ok),
    .dresp_data_ok(dresp_data_ok),
    .dresp_data   (dresp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_writereg (out_writereg),
    .out_pcplus4  (out_pcplus4),
`ifdef MEM_ADDR_CHECK_EN
    .out_exc      (out_exc),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_is_store(input logic [3:0] op);
    return (op >= 4'd6) && (op <= 4'd8);
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] word);
    int unsigned sh;
    int unsigned b;
    int unsigned h;
    sh = addr % 4;
    b  = (word >> (8 * sh)) % 256;
    h  = (word >> (16 * (sh / 2))) % 65536;
    case (op)
      4'd1: return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
      4'd2: return 32'(b);
      4'd3: return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
      4'd4: return 32'(h);
      4'd5: return word;
      default: return addr;
    endcase
  endfunction

  function automatic logic [1:0] m_size(input logic [3:0] op);
    case (op)
      4'd1, 4'd2, 4'd6: return 2'd0;
      4'd3, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] m_strobe(input logic [3:0] op, input logic [31:0] addr);
    int unsigned sh;
    sh = addr % 4;
    case (op)
      4'd6:    return 4'(1 << sh);
      4'd7:    return 4'(3 << (2 * (sh / 2)));
      4'd8:    return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_sdata(input logic [3:0] op, input logic [31:0] wd);
    case (op)
      4'd6:    return (wd % 256) * 32'h0101_0101;
      4'd7:    return (wd % 65536) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got result %h with no expected entry", out_result);
      end else begin
        logic [68:0] e;
        e = exp_q.pop_front();
        chk("mon_result", out_result, e[68:37]);
        chk("mon_writereg", 32'(out_writereg), 32'(e[36:32]));
        chk("mon_pcplus4", out_pcplus4, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic [3:0] op, input logic [31:0] alu, input logic [31:0] wd,
                      input logic [4:0] wr, input logic [31:0] pc);
    int n;
    n = 0;
    in_valid    = 1'b1;
    in_mem_op   = op;
    in_aluout   = alu;
    in_wdata    = wd;
    in_writereg = wr;
    in_pcplus4  = pc;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_mem_op = 4'd0;
  endtask

  task automatic chk_dreq(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    chk("dreq_valid", 32'(dreq_valid), 32'd1);
    chk("dreq_addr", dreq_addr, addr);
    chk("dreq_size", 32'(dreq_size), 32'(m_size(op)));
    chk("dreq_strobe", 32'(dreq_strobe), 32'(m_strobe(op, addr)));
    if (m_is_store(op)) chk("dreq_data", dreq_data, m_sdata(op, wd));
  endtask

  // Full memory transaction: addr_ok after addr_dly idle request cycles,
  // data_ok data_dly cycles after addr_ok (0 = same cycle), then out_ready
  // held low for hold cycles.
  task automatic do_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] wr, input logic [31:0] pc, input int addr_dly,
                        input int data_dly, input logic [31:0] word, input int hold);
    logic [31:0] res;
    logic [4:0]  wr_exp;
    res    = m_load(op, addr, word);
    wr_exp = m_is_store(op) ? 5'd0 : wr;
    exp_q.push_back({res, wr_exp, pc});
    send(op, addr, wd, wr, pc);
    chk_dreq(op, addr, wd);
    for (int i = 0; i < addr_dly; i++) begin
      @(posedge clk);
      #1;
      chk_dreq(op, addr, wd);
    end
    dresp_addr_ok = 1'b1;
    dresp_data_ok = (data_dly == 0);
    dresp_data    = word;
    if (data_dly == 0 && hold > 0) out_ready = 1'b0;
    @(posedge clk);
    #1;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    if (data_dly > 0) begin
      chk("dreq_drop", 32'(dreq_valid), 32'd0);
      for (int i = 0; i < data_dly - 1; i++) begin
        @(posedge clk);
        #1;
        chk("wait_no_out", 32'(out_valid), 32'd0);
      end
      dresp_data_ok = 1'b1;
      if (hold > 0) out_ready = 1'b0;
      @(posedge clk);
      #1;
      dresp_data_ok = 1'b0;
    end
    dresp_data = 32'd0;
    chk("mem_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", out_result, res);
      chk("hold_writereg", 32'(out_writereg), 32'(wr_exp));
    end
    out_ready = 1'b1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_mem_op     = 4'd0;
    in_aluout     = 32'd0;
    in_wdata      = 32'd0;
    in_writereg   = 5'd0;
    in_pcplus4    = 32'd0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = 32'd0;
    out_ready     = 1'b1;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dreq_valid", 32'(dreq_valid), 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_writereg", 32'(out_writereg), 32'd0);
    chk("rst_dreq_strobe", 32'(dreq_strobe), 32'd0);
    reset = 1'b0;

    // NONE: result one cycle after accept
    exp_q.push_back({32'h0000_1234, 5'd5, 32'h0000_0404});
    send(4'd0, 32'h0000_1234, 32'd0, 5'd5, 32'h0000_0404);
    chk("none_valid", 32'(out_valid), 32'd1);
    chk("none_result", out_result, 32'h0000_1234);
    chk("none_writereg", 32'(out_writereg), 32'd5);
    chk("none_no_dreq", 32'(dreq_valid), 32'd0);

    // Unknown op code behaves as NONE, back to back with the previous one
    exp_q.push_back({32'h0000_CAFE, 5'd31, 32'h0000_0408});
    send(4'hB, 32'h0000_CAFE, 32'd0, 5'd31, 32'h0000_0408);
    chk("undef_result", out_result, 32'h0000_CAFE);
    chk("undef_writereg", 32'(out_writereg), 32'd31);

    // LB / LBU at 0x103, addr_ok and data_ok together
    do_mem(4'd1, 32'h0000_0103, 32'd0, 5'd8, 32'h0000_0410, 0, 0, 32'h80FF_0000, 0);
    chk("lb_result", out_result, 32'hFFFF_FF80);
    chk("lb_writereg", 32'(out_writereg), 32'd8);
    do_mem(4'd2, 32'h0000_0103, 32'd0, 5'd9, 32'h0000_0414, 0, 0, 32'h80FF_0000, 0);
    chk("lbu_result", out_result, 32'h0000_0080);

    // LB positive byte in lane 2
    do_mem(4'd1, 32'h0000_0102, 32'd0, 5'd10, 32'h0000_0418, 0, 1, 32'h007F_0000, 0);
    chk("lb_pos_result", out_result, 32'h0000_007F);

    // SH at 0x102, addr_ok delayed 3 cycles
    do_mem(4'd7, 32'h0000_0102, 32'hDEAD_BEEF, 5'd11, 32'h0000_041C, 3, 1, 32'd0, 0);
    chk("sh_result", out_result, 32'h0000_0102);
    chk("sh_writereg", 32'(out_writereg), 32'd0);

    // SB, SW
    do_mem(4'd6, 32'h0000_0101, 32'h0000_12AB, 5'd12, 32'h0000_0420, 1, 2, 32'd0, 0);
    chk("sb_writereg", 32'(out_writereg), 32'd0);
    do_mem(4'd8, 32'h0000_0304, 32'h0123_4567, 5'd13, 32'h0000_0424, 0, 0, 32'd0, 0);

    // LH upper half, LHU lower half
    do_mem(4'd3, 32'h0000_0202, 32'd0, 5'd14, 32'h0000_0428, 0, 0, 32'h8001_1234, 0);
    chk("lh_result", out_result, 32'hFFFF_8001);
    do_mem(4'd4, 32'h0000_0200, 32'd0, 5'd15, 32'h0000_042C, 0, 0, 32'h8001_1234, 0);
    chk("lhu_result", out_result, 32'h0000_1234);

    // LW: addr_ok at N+1, data_ok at N+4, out_ready low for 2 cycles
    do_mem(4'd5, 32'h0000_0300, 32'd0, 5'd16, 32'h0000_0430, 0, 3, 32'h1357_9BDF, 2);
    chk("lw_result", out_result, 32'h1357_9BDF);
    chk("lw_writereg", 32'(out_writereg), 32'd16);

    // Reset while in WAIT; a late data_ok must be ignored
    @(posedge clk);
    #1;
    send(4'd5, 32'h0000_0400, 32'd0, 5'd17, 32'h0000_0434);
    chk("rw_dreq_valid", 32'(dreq_valid), 32'd1);
    dresp_addr_ok = 1'b1;
    @(posedge clk);
    #1;
    dresp_addr_ok = 1'b0;
    chk("rw_in_wait", 32'(dreq_valid), 32'd0);
    chk("rw_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rw_dreq_valid_after", 32'(dreq_valid), 32'd0);
    chk("rw_out_valid_after", 32'(out_valid), 32'd0);
    chk("rw_in_ready_after", 32'(in_ready), 32'd1);
    dresp_data_ok = 1'b1;
    dresp_data    = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    dresp_data_ok = 1'b0;
    dresp_data    = 32'd0;
    chk("late_data_ok_ignored", 32'(out_valid), 32'd0);
    chk("late_data_ok_ready", 32'(in_ready), 32'd1);

    // Still functional after the mid-transaction reset
    do_mem(4'd5, 32'h0000_0500, 32'd0, 5'd18, 32'h0000_0438, 0, 0, 32'hA5A5_5A5A, 0);
    chk("post_rst_lw", out_result, 32'hA5A5_5A5A);

`ifdef MEM_ADDR_CHECK_EN
    chk("exc_clear_aligned", 32'(out_exc), 32'd0);
    // Misaligned LW: no bus request, AdEL, BadVAddr in result
    exp_q.push_back({32'h0000_0102, 5'd0, 32'h0000_0440});
    send(4'd5, 32'h0000_0102, 32'd0, 5'd19, 32'h0000_0440);
    chk("mis_lw_no_dreq", 32'(dreq_valid), 32'd0);
    chk("mis_lw_valid", 32'(out_valid), 32'd1);
    chk("mis_lw_exc", 32'(out_exc), 32'd1);
    chk("mis_lw_result", out_result, 32'h0000_0102);
    chk("mis_lw_writereg", 32'(out_writereg), 32'd0);
    // Misaligned SH: AdES
    exp_q.push_back({32'h0000_0201, 5'd0, 32'h0000_0444});
    send(4'd7, 32'h0000_0201, 32'h1111_2222, 5'd20, 32'h0000_0444);
    chk("mis_sh_no_dreq", 32'(dreq_valid), 32'd0);
    chk("mis_sh_exc", 32'(out_exc), 32'd2);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the 5-stage MIPS core.
- Sits between the execute/memory pipeline register and the memory/writeback register, and consumes execute results.
- Issues load/store transactions on the data bus using a split address/data handshake.
- Aligns and extends load data, then presents a registered result for memory_data_t assembly in the writeback stage.

Parameters:
- ADDR_W, 32, data-bus address width.
- DATA_W, 32, data-bus data width; fixed at 32 for byte-lane logic.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept an instruction this cycle
- in_mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; other values treated as NONE
- in_aluout  in  32  ALU result; effective address for memory ops
- in_wdata  in  32  store data (rt)
- in_writereg  in  5  destination register
- in_pcplus4  in  32  passthrough
- dreq_valid  out  1  data request valid
- dreq_addr  out  32  byte address
- dreq_size  out  2  0 byte, 1 half, 2 word
- dreq_strobe  out  4  byte write enables; 0 for loads
- dreq_data  out  32  lane-replicated store data
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  data returned / write complete
- dresp_data  in  32  raw load word
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_result  out  32  load value or aluout
- out_writereg  out  5  destination; forced 0 for stores
- out_pcplus4  out  32  passthrough

Behaviour:
- Reset: state IDLE; all outputs 0, except in_ready=1.
- Handshake: in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready, which clears out_valid unless a new result lands in the same cycle.
- FSM states IDLE, REQ, WAIT.
  - IDLE, accept of NONE: out_* loaded at the next edge, out_valid=1. Latency is 1 cycle. The state stays IDLE.
  - IDLE, accept of a memory op: operands are latched; go to REQ.
  - REQ: dreq_valid=1, with addr/size/strobe/data held stable until dresp_addr_ok.
    - addr_ok with data_ok in the same cycle: result is registered, out_valid=1, go to IDLE.
    - addr_ok only: go to WAIT.
  - WAIT: dreq_valid=0. On data_ok, result is registered, out_valid=1, go to IDLE.
  - Minimum memory-op latency: accept at N, dreq_valid at N+1, out_valid at N+2.
- Load extraction, with a = addr[1:0]:
  - Byte = dresp_data[8a+7:8a].
  - Half = dresp_data[16a[1]+15:16a[1]].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Store encoding:
  - SB: strobe = 1<<a; data = {4{wdata[7:0]}}.
  - SH: strobe = 3<<(2a[1]); data = {2{wdata[15:0]}}.
  - SW: strobe = 4'hF; data = wdata.
  - out_result = aluout; out_writereg = 0.
- While out_valid && !out_ready, the next memory op is not accepted and out_* are held.
- dresp_data_ok in IDLE is ignored.
- Synchronous reset mid-transaction returns to IDLE and drops dreq_valid in the same edge. The bus is reset by the same signal.

Optional Feature:
- MEM_ADDR_CHECK_EN defined:
  - Adds output out_exc (2 bits): bit0 AdEL, bit1 AdES.
  - A misaligned access is a half-word access with addr[0]=1 or a word access with addr[1:0]≠0.
  - On accept of a misaligned access, no bus request is issued.
  - 1-cycle latency as for NONE; out_result = aluout (BadVAddr); out_writereg = 0; the matching out_exc bit is set.
- Undefined: no out_exc port; misaligned addresses go to the bus unchanged.

Test Plan:
- Reset held 2 cycles, then NONE op with aluout=0x1234, writereg=5 accepted at cycle N -> out_valid=1 at N+1, out_result=0x1234, out_writereg=5.
- LB addr=0x103, bus returns 0x80FF_0000 with addr_ok and data_ok together -> out_result=0xFFFF_FF80; LBU same stimulus -> 0x0000_0080.
- SH addr=0x102, wdata=0xDEAD_BEEF, addr_ok delayed 3 cycles -> dreq held stable with strobe=4'b1100, data=0xBEEF_BEEF, size=1; out_writereg=0 after data_ok.
- LW with addr_ok at N+1 and data_ok at N+4 -> dreq_valid drops at N+2 and out_valid rises at N+5, with out_ready held 0 for 2 cycles -> out_* stable and in_ready=0.
- Reset asserted while in WAIT -> next cycle dreq_valid=0, out_valid=0, in_ready=1; a late data_ok is ignored.
- With MEM_ADDR_CHECK_EN: LW addr=0x102 -> no dreq_valid, out_exc=2'b01, out_result=0x102 at N+1.
